// File: rtl/pipe_reg_pkg.sv
// ---------------------------------------------------------------------------
// pipe_reg_pkg
// Shared limits and helpers for the elastic pipeline register.
//   MAX_DEPTH / MAX_WIDTH : legal upper bounds for the DEPTH / WIDTH parameters
//   occ_w(depth)          : bit width needed to count 0..depth held words
//   params_ok(w, d)       : elaboration-time legality check of WIDTH/DEPTH
// ---------------------------------------------------------------------------
package pipe_reg_pkg;

  localparam int MAX_DEPTH = 8;
  localparam int MAX_WIDTH = 128;

  // Occupancy counts from 0 up to and including depth, hence depth+1 values.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit params_ok(input int width, input int depth);
    return (width >= 1) && (width <= MAX_WIDTH) &&
           (depth >= 1) && (depth <= MAX_DEPTH);
  endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// ---------------------------------------------------------------------------
// pipe_reg_stage
// One slot of the elastic pipeline: a valid flop and a data flop plus the
// local ready term of the handshake chain.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : synchronous clear of the valid bit (data left untouched)
//   up_valid    : valid of the stage (or input port) feeding this slot
//   up_data     : data of the stage (or input port) feeding this slot
//   dn_ready    : ready of the next stage (or out_ready for the last slot)
//   vld, dat    : registered contents of this slot
//   rdy         : this slot can take a new word this cycle
// ---------------------------------------------------------------------------
module pipe_reg_stage
  import pipe_reg_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             vld,
  output logic [WIDTH-1:0] dat,
  output logic             rdy
);

  logic             vld_d, vld_q;
  logic [WIDTH-1:0] dat_d, dat_q;

  // An empty slot always accepts, which is what collapses bubbles even while
  // the stages below are stalled.
  assign rdy = !vld_q || dn_ready;

  // Flush beats any load; data only moves when a real word arrives so the
  // data flops do not toggle on bubbles.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (flush) begin
      vld_d = 1'b0;
    end else if (rdy) begin
      vld_d = up_valid;
      if (up_valid) begin
        dat_d = up_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld = vld_q;
  assign dat = dat_q;

endmodule

// File: rtl/pipe_reg_elastic.sv
// ---------------------------------------------------------------------------
// pipe_reg_elastic
// DEPTH-stage pipeline register with valid/ready handshake. Stalls without
// loss or duplication, collapses bubbles, supports a synchronous flush.
// Optional feature macro: PIPE_REG_OCC_EN adds the occupancy output.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   flush                : clear all stage valid bits at the next edge
//   in_valid/in_ready    : upstream handshake, in_data the upstream word
//   out_valid/out_ready  : downstream handshake, out_data = last stage data
//   occupancy            : number of words held (PIPE_REG_OCC_EN only)
// ---------------------------------------------------------------------------
module pipe_reg_elastic
  import pipe_reg_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data
`ifdef PIPE_REG_OCC_EN
  ,
  output logic [occ_w(DEPTH)-1:0]   occupancy
`endif
);

  if (!params_ok(WIDTH, DEPTH)) begin : g_param_err
    $error("pipe_reg_elastic: WIDTH must be 1..128 and DEPTH 1..8");
  end

  logic [DEPTH-1:0] vld_vec;
  logic [WIDTH-1:0] dat_arr [DEPTH];

  // Each stage keeps its own ready net so the ready chain is a plain series
  // of separate signals rather than bits of one self-referencing vector.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             s_rdy;
    logic             s_dn_rdy;
    logic             s_up_vld;
    logic [WIDTH-1:0] s_up_dat;

    if (k == 0) begin : g_first
      assign s_up_vld = in_valid;
      assign s_up_dat = in_data;
    end else begin : g_mid
      assign s_up_vld = vld_vec[k-1];
      assign s_up_dat = dat_arr[k-1];
    end

    if (k == DEPTH - 1) begin : g_last
      assign s_dn_rdy = out_ready;
    end else begin : g_inner
      assign s_dn_rdy = g_stage[k+1].s_rdy;
    end

    pipe_reg_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .up_valid (s_up_vld),
      .up_data  (s_up_dat),
      .dn_ready (s_dn_rdy),
      .vld      (vld_vec[k]),
      .dat      (dat_arr[k]),
      .rdy      (s_rdy)
    );
  end

  assign in_ready  = g_stage[0].s_rdy;
  assign out_valid = vld_vec[DEPTH-1];
  assign out_data  = dat_arr[DEPTH-1];

`ifdef PIPE_REG_OCC_EN
  localparam int OCC_W = occ_w(DEPTH);

  // Popcount of the valid flops, so it follows vld on the same edge.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(vld_vec[i]);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// ---------------------------------------------------------------------------
// tb_pipe_reg_elastic
// Directed bench for pipe_reg_elastic (WIDTH=32, DEPTH=3). Expected values
// are hand-derived per cycle; a queue of accepted words checks output order.
// Occupancy checks are active when PIPE_REG_OCC_EN is defined.
// ---------------------------------------------------------------------------
module tb_pipe_reg_elastic;

  localparam int W = 32;
  localparam int D = 3;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef PIPE_REG_OCC_EN
  logic [$clog2(D+1)-1:0] occupancy;
`endif

  int checks;
  int failures;
  logic [W-1:0] sb [$];

  pipe_reg_elastic #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_REG_OCC_EN
    ,
    .occupancy (occupancy)
`endif
  );

  // Free-running clock, posedges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts, asserts, reports.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOcc(input string tag, input int exp);
`ifdef PIPE_REG_OCC_EN
    checkOutput(tag, 64'(occupancy), 64'(exp));
`else
    if (exp < 0) $display("[TB] %s unused", tag);
`endif
  endtask

  // Drive one cycle's inputs and let combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
  endtask

  // Record the transfers of the current cycle, then advance past the edge.
  task automatic tick();
    if (out_valid && out_ready) begin
      checkOutput("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        checkOutput("sb_order", 64'(out_data), 64'(sb[0]));
        void'(sb.pop_front());
      end
    end
    if (flush) sb.delete();
    else if (in_valid && in_ready) sb.push_back(in_data);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic         pend;
    logic [W-1:0] cnt;
    logic         prev_stall;
    logic [W-1:0] prev_data;
    checks   = 0;
    failures = 0;

    // Reset state, checked before the first clock edge.
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_data", 64'(out_data), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOcc("rst_occ", 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Back-to-back stream of 1,2,3 with out_ready=1: outputs at cycles 3,4,5.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(i < 3, W'(i + 1), 1'b1, 1'b0);
      checkOutput($sformatf("strm_in_ready_%0d", i), 64'(in_ready), 64'd1);
      checkOutput($sformatf("strm_out_valid_%0d", i), 64'(out_valid), 64'(i >= 3 && i < 6));
      if (i >= 3 && i < 6)
        checkOutput($sformatf("strm_out_data_%0d", i), 64'(out_data), 64'(i - 2));
      tick();
    end

    // Fill under back-pressure: three words accepted, then in_ready drops and
    // the first word is held; A3 is held upstream while stalled.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, (i < 3) ? W'(32'hA0 + i) : W'(32'hA3), 1'b0, 1'b0);
      checkOutput($sformatf("fill_in_ready_%0d", i), 64'(in_ready), 64'(i < 3));
      checkOcc($sformatf("fill_occ_%0d", i), (i < 3) ? i : 3);
      if (i >= 3) begin
        checkOutput($sformatf("fill_out_valid_%0d", i), 64'(out_valid), 64'd1);
        checkOutput($sformatf("fill_hold_%0d", i), 64'(out_data), 64'hA0);
      end
      tick();
    end
    // Full pipe with out_ready=1 shifts and accepts A3 in the same cycle.
    applyStimulus(1'b1, W'(32'hA3), 1'b1, 1'b0);
    checkOutput("full_release_in_ready", 64'(in_ready), 64'd1);
    checkOutput("full_release_out", 64'(out_data), 64'hA0);
    tick();
    for (int j = 1; j < 5; j++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput($sformatf("drain_valid_%0d", j), 64'(out_valid), 64'(j < 4));
      if (j < 4)
        checkOutput($sformatf("drain_data_%0d", j), 64'(out_data), 64'(32'hA0 + j));
      tick();
    end

    // Bubble collapse: valid pattern 1,0,1 under stall packs two words.
    applyStimulus(1'b1, W'(32'hB0), 1'b0, 1'b0); tick();
    applyStimulus(1'b0, W'(32'hEE), 1'b0, 1'b0); tick();
    applyStimulus(1'b1, W'(32'hB2), 1'b0, 1'b0); tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("bub_out_valid", 64'(out_valid), 64'd1);
    checkOutput("bub_out_data", 64'(out_data), 64'hB0);
    checkOcc("bub_occ_a", 2);
    tick();
    applyStimulus(1'b1, W'(32'hC0), 1'b0, 1'b0);
    checkOcc("bub_occ_b", 2);
    checkOutput("bub_in_ready", 64'(in_ready), 64'd1);
    tick();

    // Full pipe, then flush while an input transfer would happen.
    applyStimulus(1'b1, W'(32'hC1), 1'b0, 1'b0);
    checkOutput("full_in_ready", 64'(in_ready), 64'd0);
    checkOcc("full_occ", 3);
    applyStimulus(1'b1, W'(32'hC1), 1'b1, 1'b1);
    checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput($sformatf("flush_out_valid_%0d", i), 64'(out_valid), 64'd0);
      checkOcc($sformatf("flush_occ_%0d", i), 0);
      if (i == 0) checkOutput("flush_dat_kept", 64'(out_data), 64'hB0);
      tick();
    end

    // Asynchronous reset between edges while full and stalled.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, W'(32'hD0 + i), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("pre_rst_data", 64'(out_data), 64'hD0);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("arst_out_data", 64'(out_data), 64'd0);
    checkOutput("arst_in_ready", 64'(in_ready), 64'd1);
    checkOcc("arst_occ", 0);
    sb.delete();
    tick();
    rst_n = 1'b1;

    // Patterned valid/ready traffic; upstream holds a word until accepted.
    pend       = 1'b0;
    cnt        = W'(32'h100);
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int i = 0; i < 80; i++) begin
      applyStimulus(pend || ((i % 3) != 2), cnt, (i % 5) < 2 || (i % 7) == 6, 1'b0);
      if (prev_stall) begin
        checkOutput($sformatf("stall_valid_%0d", i), 64'(out_valid), 64'd1);
        checkOutput($sformatf("stall_data_%0d", i), 64'(out_data), 64'(prev_data));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      pend       = in_valid && !in_ready;
      if (in_valid && in_ready) cnt = cnt + 1'b1;
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      tick();
    end
    checkOutput("drain_sb_empty", 64'(sb.size()), 64'd0);
    checkOutput("drain_out_valid", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
